muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised multicycle multiply/divide engine that replaces the separate fixed 32-bit mult and div blocks feeding the HI/LO registers of the multicycle CPU. A single shared iterative datapath supports signed and unsigned multiply and divide, selected by an op code. The control unit uses a start/busy/done handshake and a divide-by-zero flag.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be >= 4.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  request; sampled only when busy=0
op  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with start
a  in  WIDTH  multiplicand / dividend (RegA)
b  in  WIDTH  multiplier / divisor (RegB)
busy  out  1  operation in progress
done  out  1  one-cycle pulse; hi/lo/div0 valid in this cycle
div0  out  1  high together with done when a DIV/DIVU had b==0
hi  out  WIDTH  MULT: upper product; DIV: remainder
lo  out  WIDTH  MULT: lower product; DIV: quotient

Behaviour:
- On reset: state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0, counter=0. A reset in the middle of an operation aborts it with no done pulse.
- States: IDLE, CALC, FIX. Transitions: IDLE->CALC on start; CALC->FIX after WIDTH iterations; FIX->IDLE. The special case IDLE->IDLE on start with a DIV op and b==0 is described below.
- On the start edge: latch op, latch the sign bits of a and b, latch the magnitudes of a and b (two's-complement absolute value for signed ops, raw value for unsigned), clear the accumulator, and set counter=0.
- CALC, multiply: radix-2 shift-add, one bit per cycle over a 2*WIDTH accumulator.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
- FIX, one cycle:
  - Signed multiply: negate the 2*WIDTH product if sign(a) differs from sign(b).
  - Signed divide: the quotient is negative if the signs differ. The remainder takes the sign of the dividend (truncation toward zero, MIPS semantics).
  - Write hi/lo and assert done for one cycle.
- Latency: done is high exactly WIDTH+2 cycles after the cycle in which start is sampled. busy is high from the next cycle through the cycle before done. busy=0 in the done cycle.
- start while busy=1 is ignored and does not corrupt the running operation. start in the done cycle is accepted (back-to-back operation).
- Divide by zero (DIV/DIVU with b==0): no CALC. In the next cycle done=1 and div0=1, and hi/lo keep their previous values. busy stays 0.
- Signed DIV of the most-negative value by -1: quotient wraps to the most-negative value, remainder is 0, div0=0.
- hi/lo change only on the FIX edge. They hold their value otherwise, including while busy.
- Outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - state encoding IDLE/CALC/FIX.
  - helper function is_div(op).
- Sub-module muldiv_iter_core, parametrised by WIDTH:
  - Holds the 2*WIDTH accumulator and the one-step add/shift and subtract/shift logic.
  - Inputs: mode, step, load.
  - The FSM, counter, sign fix-up and handshake stay in muldiv_unit.

Test Plan:
- WIDTH=32, MULT a=-3 (0xFFFFFFFD), b=7 -> done at start+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div0=0.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE. Then DIVU a=7, b=2 issued in the done cycle -> second done 34 cycles later, lo=3, hi=1.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- With hi=0x11, lo=0x22 from a prior operation, DIV b=0 -> done=1 and div0=1 one cycle after start, busy never high, hi=0x11, lo=0x22 unchanged.
- During a MULT, pulse start with new operands at start+5 -> ignored, result matches the original operands. Assert reset at start+10 -> next cycle busy=0, hi=lo=0, no done pulse.
- WIDTH=8 instance, MULT a=0x80, b=0x80 -> done at start+10, hi=0x40, lo=0x00. DIV a=0x81 (-127), b=0x0A -> lo=0xF4 (-12), hi=0xF9 (-7).

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encodings and op-decode helpers for the multiply/divide engine.
// Pure declarations: no latency, no flow control.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    function automatic logic is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared 2*WIDTH accumulator: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
// Latency: one step per i_step cycle; i_load overrides i_step. No backpressure: steps are driven by the caller.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_div_mode,
    input  logic [WIDTH-1:0]     i_load_lo,
    input  logic [WIDTH-1:0]     i_load_opnd,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;

    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]     w_add_sum;
    logic [WIDTH:0]     w_sub_pr;
    logic [WIDTH:0]     w_sub_diff;
    logic               w_sub_ok;

    always_comb begin
        w_add_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
        // Partial remainder after the left shift needs WIDTH+1 bits to stay exact.
        w_sub_pr   = r_acc[2*WIDTH-1:WIDTH-1];
        w_sub_diff = w_sub_pr - {1'b0, r_opnd};
        w_sub_ok   = ~w_sub_diff[WIDTH];
        w_acc_nxt  = r_acc;
        if (i_div_mode) begin
            w_acc_nxt = {(w_sub_ok ? w_sub_diff[WIDTH-1:0] : w_sub_pr[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_sub_ok};
        end else if (r_acc[0]) begin
            w_acc_nxt = {w_add_sum, r_acc[WIDTH-1:1]};
        end else begin
            w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (i_load) begin
            r_acc  <= {{WIDTH{1'b0}}, i_load_lo};
            r_opnd <= i_load_opnd;
        end else if (i_step) begin
            r_acc  <= w_acc_nxt;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide feeding HI/LO; start/busy/done handshake with divide-by-zero flag.
// Latency: done exactly WIDTH+2 cycles after start is sampled (1 cycle for divide by zero).
// Backpressure: start is ignored while busy; start in the done cycle is accepted.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic               w_accept;
    logic               w_div0_hit;
    logic               w_load;
    logic               w_signed_in;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic               w_r_signed;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_div0_hit  = w_accept && is_div(op) && (b == '0);
    assign w_load      = w_accept && !w_div0_hit;
    assign w_signed_in = is_signed_op(op);
    assign w_mag_a     = (w_signed_in && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_mag_b     = (w_signed_in && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign w_r_signed  = is_signed_op(r_op);

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_step      (r_state == S_CALC),
        .i_div_mode  (is_div(r_op)),
        .i_load_lo   (is_div(op) ? w_mag_a : w_mag_b),
        .i_load_opnd (is_div(op) ? w_mag_b : w_mag_a),
        .o_acc       (w_acc)
    );

    // Sign fix-up: quotient/product negative on sign mismatch, remainder follows the dividend.
    always_comb begin
        w_prod   = w_acc;
        w_fix_hi = w_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = w_acc[WIDTH-1:0];
        if (is_div(r_op)) begin
            if (w_r_signed && (r_sign_a ^ r_sign_b)) begin
                w_fix_lo = ~w_acc[WIDTH-1:0] + 1'b1;
            end
            if (w_r_signed && r_sign_a) begin
                w_fix_hi = ~w_acc[2*WIDTH-1:WIDTH] + 1'b1;
            end
        end else begin
            if (w_r_signed && (r_sign_a ^ r_sign_b)) begin
                w_prod = ~w_acc + 1'b1;
            end
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= OP_MULT;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_div0_hit) begin
                        r_done <= 1'b1;
                        r_div0 <= 1'b1;
                    end else if (w_accept) begin
                        r_state  <= S_CALC;
                        r_busy   <= 1'b1;
                        r_op     <= op;
                        r_sign_a <= a[WIDTH-1];
                        r_sign_b <= b[WIDTH-1];
                        r_cnt    <= '0;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign div0 = r_div0;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32 = 1'b1, st32 = 1'b0;
    logic [1:0]  op32 = 2'b00;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, div032;
    logic [31:0] hi32, lo32;

    logic        rst8 = 1'b1, st8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, div08;
    logic [7:0]  hi8, lo8;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(rst32), .start(st32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .div0(div032), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .start(st8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div0(div08), .hi(hi8), .lo(lo8)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; returns cycles until done (or -1 on timeout).
    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output bit busy_seen);
        op32 = o; a32 = x; b32 = y; st32 = 1'b1;
        lat = 0; busy_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            st32 = 1'b0;
            lat++;
            if (busy32) busy_seen = 1'b1;
            if (done32) break;
        end
        if (!done32) lat = -1;
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat);
        op8 = o; a8 = x; b8 = y; st8 = 1'b1;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            st8 = 1'b0;
            lat++;
            if (done8) break;
        end
        if (!done8) lat = -1;
    endtask

    initial begin
        int lat;
        bit bs;
        bit done_seen;

        tick(); tick();
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_div0", 64'(div032), 64'd0);
        check("rst_hi",   64'(hi32),   64'd0);
        check("rst_lo",   64'(lo32),   64'd0);
        rst32 = 1'b0;
        rst8  = 1'b0;
        tick();

        // -3 * 7 = -21
        run32(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bs);
        check("mult_lat",  64'(lat),    64'd34);
        check("mult_busy", 64'(bs),     64'd1);
        check("mult_hi",   64'(hi32),   64'hFFFF_FFFF);
        check("mult_lo",   64'(lo32),   64'hFFFF_FFEB);
        check("mult_div0", 64'(div032), 64'd0);
        tick();

        run32(OP_MULTU, 32'hFFFF_FFFF, 32'd2, lat, bs);
        check("multu_hi", 64'(hi32), 64'h1);
        check("multu_lo", 64'(lo32), 64'hFFFF_FFFE);
        // Issued in the done cycle of the previous op.
        run32(OP_DIVU, 32'd7, 32'd2, lat, bs);
        check("b2b_lat", 64'(lat),  64'd34);
        check("b2b_lo",  64'(lo32), 64'd3);
        check("b2b_hi",  64'(hi32), 64'd1);
        tick();

        run32(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bs);
        check("div_neg_lo", 64'(lo32), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(hi32), 64'hFFFF_FFFF);
        tick();
        check("done_pulse", 64'(done32), 64'd0);

        run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bs);
        check("div_ovf_lo",   64'(lo32),   64'h8000_0000);
        check("div_ovf_hi",   64'(hi32),   64'h0);
        check("div_ovf_div0", 64'(div032), 64'd0);
        tick();

        // 0x451 / 0x20 = 0x22 rem 0x11
        run32(OP_DIVU, 32'h451, 32'h20, lat, bs);
        check("pre_lo", 64'(lo32), 64'h22);
        check("pre_hi", 64'(hi32), 64'h11);
        tick();
        run32(OP_DIV, 32'd5, 32'd0, lat, bs);
        check("dz_lat",  64'(lat),    64'd1);
        check("dz_div0", 64'(div032), 64'd1);
        check("dz_busy", 64'(bs),     64'd0);
        check("dz_hi",   64'(hi32),   64'h11);
        check("dz_lo",   64'(lo32),   64'h22);
        tick();
        check("dz_div0_clr", 64'(div032), 64'd0);

        // Second start while busy must be ignored.
        op32 = OP_MULT; a32 = 32'd5; b32 = 32'd6; st32 = 1'b1;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            st32 = 1'b0;
            if (n == 5) begin
                op32 = OP_DIV; a32 = 32'd100; b32 = 32'd100; st32 = 1'b1;
            end
            if (done32) begin
                lat = n;
                break;
            end
        end
        check("ign_lat", 64'(lat),  64'd34);
        check("ign_hi",  64'(hi32), 64'd0);
        check("ign_lo",  64'(lo32), 64'd30);
        tick();

        // Reset mid-operation aborts without a done pulse.
        op32 = OP_MULT; a32 = 32'd3; b32 = 32'd4; st32 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            st32 = 1'b0;
        end
        rst32 = 1'b1;
        tick();
        rst32 = 1'b0;
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_hi",   64'(hi32),   64'd0);
        check("abort_lo",   64'(lo32),   64'd0);
        done_seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done32) done_seen = 1'b1;
            tick();
        end
        check("abort_nodone", 64'(done_seen), 64'd0);

        // WIDTH=8 instance: (-128)*(-128) = 0x4000
        run8(OP_MULT, 8'h80, 8'h80, lat);
        check("w8_mult_lat", 64'(lat), 64'd10);
        check("w8_mult_hi",  64'(hi8), 64'h40);
        check("w8_mult_lo",  64'(lo8), 64'h00);
        tick();
        run8(OP_DIV, 8'h81, 8'h0A, lat);
        check("w8_div_lo", 64'(lo8), 64'hF4);
        check("w8_div_hi", 64'(hi8), 64'hF9);
        tick();
        run8(OP_MULTU, 8'hFF, 8'hFF, lat);
        check("w8_multu_hi", 64'(hi8), 64'hFE);
        check("w8_multu_lo", 64'(lo8), 64'h01);
        tick();
        run8(OP_DIVU, 8'hFF, 8'h0F, lat);
        check("w8_divu_lo", 64'(lo8), 64'h11);
        check("w8_divu_hi", 64'(hi8), 64'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
